// File: rtl/hazard3_timer_alarm_sched.sv
// Alarm scheduler: folds N 64-bit alarm slots onto the single machine-timer mtimecmp over APB.
// Latency: N_ALARMS scan cycles plus three APB writes (2 cycles each plus pready wait states).
// Backpressure: WR_ACCESS holds psel/penable until pready; slot updates are always accepted.
module hazard3_timer_alarm_sched #(
    parameter int          N_ALARMS   = 4,
    parameter int          IDX_W      = 2,
    parameter logic [15:0] TIMER_BASE = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_valid,
    input  logic [IDX_W-1:0]    set_idx,
    input  logic [63:0]         set_deadline,
    input  logic                clr_valid,
    input  logic [IDX_W-1:0]    clr_idx,
    input  logic [63:0]         mtime,
    input  logic                timer_irq,
    output logic [N_ALARMS-1:0] alarm_fired,
    output logic [N_ALARMS-1:0] alarm_pending,
    output logic                busy,
    output logic                bus_err,
    output logic [15:0]         paddr,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [31:0]         pwdata,
    input  logic                pready,
    input  logic                pslverr
);

    typedef enum logic [1:0] {IDLE, SCAN, WR_SETUP, WR_ACCESS} state_t;

    localparam logic [15:0] ADDR_LO = TIMER_BASE + 16'h0010;
    localparam logic [15:0] ADDR_HI = TIMER_BASE + 16'h0014;

    state_t               state, state_nxt;
    logic [63:0]          deadline [N_ALARMS];
    logic [N_ALARMS-1:0]  valid;
    logic                 dirty, armed, found;
    logic [63:0]          min_dl;
    logic [IDX_W-1:0]     scan_idx;
    logic [1:0]           step;

    logic                 scan_last, expired, set_hit, fire_now, load_min;
    logic                 start_scan, xfer_done;
    logic [N_ALARMS-1:0]  fire_vec;

    assign scan_last  = (scan_idx == IDX_W'(N_ALARMS - 1));
    assign expired    = (state == SCAN) && valid[scan_idx] && (deadline[scan_idx] <= mtime);
    assign set_hit    = set_valid && (set_idx == scan_idx);
    assign fire_now   = expired && !set_hit;
    assign load_min   = (state == SCAN) && !expired && valid[scan_idx] && (deadline[scan_idx] < min_dl);
    assign start_scan = (state == IDLE) && (state_nxt == SCAN);
    assign xfer_done  = (state == WR_ACCESS) && pready;

    always_comb begin
        state_nxt = state;
        psel      = 1'b0;
        penable   = 1'b0;
        paddr     = 16'h0000;
        pwdata    = 32'h0000_0000;
        fire_vec  = '0;
        if (fire_now) fire_vec[scan_idx] = 1'b1;
        case (state)
            IDLE:      if (dirty || (timer_irq && armed)) state_nxt = SCAN;
            SCAN:      if (scan_last) state_nxt = WR_SETUP;
            WR_SETUP:  state_nxt = WR_ACCESS;
            WR_ACCESS: if (pready) state_nxt = (step == 2'd2) ? IDLE : WR_SETUP;
            default:   state_nxt = IDLE;
        endcase
        if (state == WR_SETUP || state == WR_ACCESS) begin
            psel    = 1'b1;
            penable = (state == WR_ACCESS);
            paddr   = (step == 2'd1) ? ADDR_HI : ADDR_LO;
            // Low word is parked at all-ones first so the half-written compare can never match early.
            case (step)
                2'd0:    pwdata = 32'hFFFF_FFFF;
                2'd1:    pwdata = min_dl[63:32];
                default: pwdata = min_dl[31:0];
            endcase
        end
    end

    assign pwrite        = psel;
    assign busy          = (state != IDLE);
    assign alarm_pending = valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < N_ALARMS; i++) deadline[i] <= 64'd0;
        end else begin
            for (int i = 0; i < N_ALARMS; i++) begin
                if (set_valid && set_idx == IDX_W'(i)) begin
                    valid[i]    <= 1'b1;
                    deadline[i] <= set_deadline;
                end else if ((clr_valid && clr_idx == IDX_W'(i)) ||
                             (fire_vec[i])) begin
                    valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dirty       <= 1'b0;
            armed       <= 1'b0;
            found       <= 1'b0;
            min_dl      <= '1;
            scan_idx    <= '0;
            step        <= 2'd0;
            bus_err     <= 1'b0;
            alarm_fired <= '0;
        end else begin
            alarm_fired <= fire_vec;
            // An update racing the scan start keeps dirty so nothing is lost.
            if (set_valid || clr_valid) dirty <= 1'b1;
            else if (start_scan)        dirty <= 1'b0;
            if (start_scan) begin
                scan_idx <= '0;
                min_dl   <= '1;
                found    <= 1'b0;
            end else if (state == SCAN) begin
                scan_idx <= scan_idx + 1'b1;
                if (load_min) begin
                    min_dl <= deadline[scan_idx];
                    found  <= 1'b1;
                end
                if (scan_last) step <= 2'd0;
            end
            if (xfer_done) begin
                if (pslverr) bus_err <= 1'b1;
                if (step == 2'd2) armed <= found;
                else              step  <= step + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard3_timer_alarm_sched.sv
// Bench for hazard3_timer_alarm_sched: directed cases plus randomized arm/clear bursts checked
// against a slot-set model; a behavioural machine timer answers the APB writes and raises timer_irq.
module tb_hazard3_timer_alarm_sched;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_valid, clr_valid;
    logic [1:0]  set_idx, clr_idx;
    logic [63:0] set_deadline;
    logic [63:0] mtime;
    logic        timer_irq;
    logic [N-1:0] alarm_fired, alarm_pending;
    logic        busy, bus_err;
    logic [15:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic        pready, pslverr;

    logic        force_low = 1'b0;
    logic        rnd_rdy   = 1'b1;
    logic        err_hi    = 1'b0;

    hazard3_timer_alarm_sched #(.N_ALARMS(N), .IDX_W(2), .TIMER_BASE(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .set_valid(set_valid), .set_idx(set_idx), .set_deadline(set_deadline),
        .clr_valid(clr_valid), .clr_idx(clr_idx),
        .mtime(mtime), .timer_irq(timer_irq),
        .alarm_fired(alarm_fired), .alarm_pending(alarm_pending),
        .busy(busy), .bus_err(bus_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    assign pready  = force_low ? 1'b0 : rnd_rdy;
    assign pslverr = err_hi && (paddr == 16'h0014);

    always @(posedge clk) rnd_rdy <= ($urandom_range(0, 2) != 0);

    // Behavioural machine timer: compare registers written over APB, registered interrupt.
    logic [31:0] cmp_lo, cmp_hi;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            cmp_lo    <= 32'hFFFF_FFFF;
            cmp_hi    <= 32'hFFFF_FFFF;
            timer_irq <= 1'b0;
        end else begin
            timer_irq <= (mtime >= {cmp_hi, cmp_lo});
            if (psel && penable && pready) begin
                if (paddr == 16'h0010) cmp_lo <= pwdata;
                if (paddr == 16'h0014) cmp_hi <= pwdata;
            end
        end
    end

    // Monitor: write log, fire-pulse counters and APB protocol watch.
    logic [15:0] wa [3];
    logic [31:0] wd [3];
    int          wr_cnt = 0;
    int          proto_err = 0;
    int          fire_cnt [N] = '{default: 0};
    logic [15:0] setup_addr;
    logic [31:0] setup_data;
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) if (alarm_fired[i] === 1'b1) fire_cnt[i] <= fire_cnt[i] + 1;
        if (psel === 1'b1 && penable === 1'b0) begin
            setup_addr <= paddr;
            setup_data <= pwdata;
        end
        if (psel === 1'b1 && penable === 1'b1 &&
            (paddr !== setup_addr || pwdata !== setup_data)) proto_err <= proto_err + 1;
        if (pwrite !== psel) proto_err <= proto_err + 1;
        if (psel === 1'b1 && penable === 1'b1 && pready === 1'b1) begin
            wa[0] <= wa[1]; wa[1] <= wa[2]; wa[2] <= paddr;
            wd[0] <= wd[1]; wd[1] <= wd[2]; wd[2] <= pwdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [N-1:0] m_valid = '0;
    logic [63:0] m_dl [N];
    logic [N-1:0] exp_fire = '0;
    logic        exp_bus_err = 1'b0;
    int          fire_base [N] = '{default: 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic op_set(input int idx, input logic [63:0] dl);
        set_valid = 1'b1; set_idx = 2'(idx); set_deadline = dl;
        m_valid[idx] = 1'b1; m_dl[idx] = dl;
        @(posedge clk); #1;
        set_valid = 1'b0;
    endtask

    task automatic op_clr(input int idx);
        clr_valid = 1'b1; clr_idx = 2'(idx);
        m_valid[idx] = 1'b0;
        @(posedge clk); #1;
        clr_valid = 1'b0;
    endtask

    task automatic quiesce();
        int run = 0;
        int n = 0;
        while (run < 8 && n < 3000) begin
            @(negedge clk);
            run = busy ? 0 : run + 1;
            n++;
        end
        chk("quiesce_timeout", 64'(run >= 8), 64'd1);
    endtask

    task automatic wait_setup();
        int n = 0;
        @(negedge clk);
        while (!(psel === 1'b1 && penable === 1'b0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("setup_timeout", 64'(n < 500), 64'd1);
    endtask

    // Every armed slot whose deadline is not in the future expires exactly once.
    task automatic model_fire();
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_dl[i] <= mtime) begin
                exp_fire[i] = 1'b1;
                m_valid[i]  = 1'b0;
            end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] mn;
        mn = '1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_fire%0d", tag, i), 64'(fire_cnt[i] - fire_base[i]), 64'(exp_fire[i]));
            fire_base[i] = fire_cnt[i];
            if (m_valid[i] && m_dl[i] < mn) mn = m_dl[i];
        end
        exp_fire = '0;
        chk({tag, "_pending"}, 64'(alarm_pending), 64'(m_valid));
        chk({tag, "_wa0"}, 64'(wa[0]), 64'h10);
        chk({tag, "_wa1"}, 64'(wa[1]), 64'h14);
        chk({tag, "_wa2"}, 64'(wa[2]), 64'h10);
        chk({tag, "_wd0"}, 64'(wd[0]), 64'hFFFF_FFFF);
        chk({tag, "_wd1"}, 64'(wd[1]), 64'(mn[63:32]));
        chk({tag, "_wd2"}, 64'(wd[2]), 64'(mn[31:0]));
        chk({tag, "_bus_err"}, 64'(bus_err), 64'(exp_bus_err));
    endtask

    initial begin
        int p [N];
        int nops, w0;
        logic [15:0] held_addr;
        rst = 1'b1; set_valid = 1'b0; clr_valid = 1'b0; set_idx = '0; clr_idx = '0;
        set_deadline = '0; mtime = 64'd100;
        #1;
        chk("rst_fired",   64'(alarm_fired),   64'd0);
        chk("rst_pending", 64'(alarm_pending), 64'd0);
        chk("rst_busy",    64'(busy),          64'd0);
        chk("rst_bus_err", 64'(bus_err),       64'd0);
        chk("rst_apb",     {29'd0, psel, penable, pwrite, paddr, 2'b00, pwdata[31:2]}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single alarm
        op_set(2, 64'd150);
        quiesce(); check_all("single_arm");
        mtime = 64'd150;
        quiesce(); model_fire(); check_all("single_fire");

        // Ordering across the 32-bit boundary
        mtime = 64'd0;
        op_set(0, 64'd500); op_set(1, 64'd300); op_set(3, 64'h1_0000_0010);
        quiesce(); check_all("order_arm");
        mtime = 64'd300;
        quiesce(); model_fire(); check_all("order_fire");
        op_clr(0); op_clr(3);
        quiesce(); check_all("order_clr");

        // Deadline already past when armed
        mtime = 64'd1000;
        op_set(0, 64'd10);
        quiesce(); model_fire(); check_all("past");

        // Randomized bursts on distinct slots, then time advance
        mtime = 64'd2000 + (64'($urandom_range(0, 2)) << 32) + 64'($urandom);
        for (int ep = 0; ep < 25; ep++) begin
            for (int i = 0; i < N; i++) p[i] = i;
            for (int i = N - 1; i > 0; i--) begin
                int j, t;
                j = $urandom_range(0, i); t = p[i]; p[i] = p[j]; p[j] = t;
            end
            nops = $urandom_range(1, 3);
            for (int k = 0; k < nops; k++) begin
                if ($urandom_range(0, 3) == 0) op_clr(p[k]);
                else case ($urandom_range(0, 3))
                    0:       op_set(p[k], mtime - 64'($urandom_range(0, 500)));
                    1, 2:    op_set(p[k], mtime + 64'($urandom_range(1, 600)));
                    default: op_set(p[k], mtime + (64'($urandom_range(1, 3)) << 32) + 64'($urandom_range(0, 999)));
                endcase
                if ($urandom_range(0, 1) == 1) @(negedge clk);
            end
            quiesce(); model_fire(); check_all($sformatf("rnd%0d_ops", ep));
            mtime = mtime + 64'($urandom_range(0, 700));
            quiesce(); model_fire(); check_all($sformatf("rnd%0d_adv", ep));
        end

        // Set and clear of one slot together while an access is stalled
        w0 = wr_cnt;
        op_set(0, mtime + 64'd900);
        wait_setup();
        force_low = 1'b1;
        @(posedge clk); #1;
        set_valid = 1'b1; set_idx = 2'd1; set_deadline = mtime + 64'd800;
        clr_valid = 1'b1; clr_idx = 2'd1;
        m_valid[1] = 1'b1; m_dl[1] = mtime + 64'd800;
        @(negedge clk);
        held_addr = paddr;
        @(posedge clk); #1;
        set_valid = 1'b0; clr_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall_psel%0d", k),    64'(psel),    64'd1);
            chk($sformatf("stall_penable%0d", k), 64'(penable), 64'd1);
            chk($sformatf("stall_paddr%0d", k),   64'(paddr),   64'(held_addr));
        end
        force_low = 1'b0;
        quiesce();
        chk("stall_rescan", 64'(wr_cnt - w0 >= 6), 64'd1);
        check_all("stall");

        // Slave error on the high-word write
        err_hi = 1'b1;
        op_set(2, mtime + 64'd400);
        quiesce();
        err_hi = 1'b0;
        exp_bus_err = 1'b1;
        check_all("slverr");

        // Reset in the middle of an access
        op_set(3, mtime + 64'd300);
        wait_setup();
        force_low = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_psel",    64'(psel),          64'd0);
        chk("arst_penable", 64'(penable),       64'd0);
        chk("arst_bus_err", 64'(bus_err),       64'd0);
        chk("arst_pending", 64'(alarm_pending), 64'd0);
        chk("arst_busy",    64'(busy),          64'd0);
        m_valid = '0;
        exp_bus_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        force_low = 1'b0;
        op_set(1, mtime + 64'd250);
        quiesce(); check_all("post_rst");

        chk("apb_protocol", 64'(proto_err), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard3_timer_alarm_sched.md
Name: hazard3_timer_alarm_sched

Overview:
Multiplexes N_ALARMS independent 64-bit hardware alarm slots onto the single mtimecmp of the RISC-V machine timer. It scans the armed slots, fires every slot whose deadline has passed, and programs the earliest remaining deadline into the timer through its own APB master port. It sits beside the timer as a second APB requester, behind the system APB arbiter, and reads mtime and timer_irq as sideband inputs.

Parameters:
N_ALARMS, 4, number of alarm slots (power of 2, 2..16)
IDX_W, 2, slot index width, equal to log2(N_ALARMS)
TIMER_BASE, 16'h0000, APB base of the timer. mtimecmp is at +0x10 and mtimecmph is at +0x14.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
set_valid  in  1  arm slot set_idx with set_deadline
set_idx  in  IDX_W  slot to arm
set_deadline  in  64  absolute mtime deadline
clr_valid  in  1  disarm slot clr_idx
clr_idx  in  IDX_W  slot to disarm
mtime  in  64  current timer count
timer_irq  in  1  timer compare interrupt (registered in the timer)
alarm_fired  out  N_ALARMS  one-cycle pulse per slot on expiry
alarm_pending  out  N_ALARMS  slot armed flags
busy  out  1  FSM not in IDLE
bus_err  out  1  sticky, set when pslverr is seen on any access
paddr  out  16  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  always 1 while psel is high
pwdata  out  32  APB write data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
- Reset: all outputs 0. Slots are invalid, dirty=0, armed=0, FSM is in IDLE.
- Slot update, same cycle, in every state:
  - set_valid writes deadline[set_idx] and sets valid[set_idx].
  - clr_valid clears valid[clr_idx].
  - If set and clr target the same slot in the same cycle, set wins.
  - Any set or clr sets dirty.
- FSM states: IDLE, SCAN, WR_SETUP, WR_ACCESS.
- IDLE:
  - Goes to SCAN when dirty is set, or when timer_irq && armed.
  - Entering SCAN clears dirty, sets scan index to 0, and sets min to all-ones with found=0.
- SCAN: examines one slot per cycle, indices 0..N_ALARMS-1, so the scan takes N_ALARMS cycles.
  - If the slot is valid and deadline <= mtime (unsigned 64-bit compare), clear valid and pulse alarm_fired[i] on the next cycle.
  - If set_valid hits that same slot in the same cycle, the set wins and there is no fire.
  - Otherwise, if the slot is valid and deadline < min, load min and set found.
  - After the last slot, go to WR_SETUP with step 0.
- Write sequence. Three APB writes, in step order:
  - Step 0: mtimecmp <= 32'hFFFFFFFF.
  - Step 1: mtimecmph <= min[63:32].
  - Step 2: mtimecmp <= min[31:0].
  - If found=0, min stays all-ones, which parks the comparator.
- APB handshake:
  - WR_SETUP drives psel=1, penable=0, with paddr and pwdata valid. It lasts exactly one cycle, then goes to WR_ACCESS.
  - WR_ACCESS drives psel=1, penable=1 and holds until pready=1.
  - On the pready cycle: pslverr sets bus_err, which stays set until reset. The step advances regardless of the error.
  - After step 2: armed <= found, deassert psel, go to IDLE.
- A set or clr that arrives during SCAN or the writes leaves dirty set, so IDLE immediately rescans. No update is lost.
- A deadline already in the past when programmed causes a timer_irq, which triggers a rescan, which fires the slot. Stale timer_irq after reprogramming only causes a harmless extra scan.
- Asynchronous rst mid-transfer drops psel and penable immediately. Slots are lost.

Test Plan:
- Single alarm: mtime=100, set slot 2 deadline=150, then assert timer_irq once mtime>=150.
  -> Writes 0x10=FFFFFFFF, 0x14=0, 0x10=150. Then alarm_fired=4'b0100 for one cycle. Rescan programs 0xFFFFFFFF/0xFFFFFFFF and armed=0.
- Ordering: mtime=0, arm slot0=500, slot1=300, slot3=0x1_0000_0010.
  -> The last write sequence programs mtimecmph=0 and mtimecmp=300. After slot1 fires, a rescan programs 500.
- Past deadline: mtime=1000, set slot0=10.
  -> The first SCAN clears slot0 and pulses alarm_fired[0] with no irq wait. The writes program all-ones.
- Simultaneous: set and clr of slot1 in the same cycle, while the FSM is in WR_ACCESS with pready held low for 5 cycles.
  -> psel and penable stay held with stable paddr. slot1 ends pending. dirty forces a rescan right after step 2.
- Error and reset: pslverr=1 on step 1.
  -> bus_err=1 and the sequence completes. A later rst pulse mid-WR_ACCESS gives psel=0, bus_err=0, and alarm_pending=0 immediately.
